// File: rtl/dm_pkg.sv
// ============================================================================
//  Module   : dm_pkg
//  Brief    : Shared types, constants and byte-merge helper for the data
//             memory model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int RD_LAT_MAX     = 4;

    // Lane i of wdata replaces lane i of old_word wherever byteen[i] is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_rd_pipe.sv
// ============================================================================
//  Module   : dm_rd_pipe
//  Brief    : Read-return delay line of {valid, data}, LAT stages deep;
//             LAT = 0 is a plain pass-through.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dm_rd_pipe #(
    parameter int LAT = 1,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ reset;
            assign valid_o     = valid_i;
            assign data_o      = valid_i ? data_i : '0;
        end else begin : g_pipe
            logic [LAT-1:0] vld_q;
            logic [W-1:0]   dat_q [LAT];

            // Data is zeroed on entry so an idle slot always carries 0.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= valid_i;
                    dat_q[0] <= valid_i ? data_i : '0;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign valid_o = vld_q[LAT-1];
            assign data_o  = dat_q[LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dm_model_ctrl.sv
// ============================================================================
//  Module   : dm_model_ctrl
//  Brief    : Byte-enabled data memory model with post-reset clear engine,
//             out-of-range detection and a committed-write event record.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dm_model_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH  = 4096,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int          RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        err_oob,
    output logic        ev_valid,
    output logic [31:0] ev_addr,
    output logic [31:0] ev_wdata,
    output logic [31:0] ev_pc
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    dm_state_e   state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [31:0] mem_q [DEPTH];

    logic        err_oob_q;
    logic        ev_valid_q;
    logic [31:0] ev_addr_q, ev_wdata_q, ev_pc_q;

    logic [31:0] off, word_off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, merged, rd_sample, pipe_data;
    logic        wr_req, rd_req, wr_commit, oob;
    logic        unused_bits;

    assign busy        = (state_q == CLEAR);
    assign unused_bits = ^{off[1:0], req_addr[1:0]};

    always_comb begin
        off       = req_addr - BASE;
        word_off  = {2'b00, off[31:2]};
        in_range  = (req_addr >= BASE) && (word_off < 32'(DEPTH));
        idx       = off[AW+1:2];
        rd_word   = in_range ? mem_q[idx] : '0;
        merged    = byte_merge(rd_word, req_wdata, req_byteen);
        wr_req    = !reset && !busy && (|req_byteen);
        rd_req    = !reset && !busy && rd_en;
        wr_commit = wr_req && in_range;
        oob       = (wr_req || rd_req) && !in_range;
        // Registered reads see the same-cycle write; the combinational path
        // returns the pre-write contents.
        rd_sample = (RD_LAT == 0) ? rd_word : (wr_commit ? merged : rd_word);
        pipe_data = rd_req ? rd_sample : '0;
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            err_oob_q  <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_addr_q  <= '0;
            ev_wdata_q <= '0;
            ev_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            err_oob_q  <= oob;
            ev_valid_q <= wr_commit;
            if (wr_commit) begin
                ev_addr_q  <= {req_addr[31:2], 2'b00};
                ev_wdata_q <= merged;
                ev_pc_q    <= req_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_commit) begin
                mem_q[idx] <= merged;
            end
        end
    end

    dm_rd_pipe #(
        .LAT (RD_LAT),
        .W   (32)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .valid_i (rd_req),
        .data_i  (pipe_data),
        .valid_o (rd_valid),
        .data_o  (rd_data)
    );

    assign err_oob  = err_oob_q;
    assign ev_valid = ev_valid_q;
    assign ev_addr  = ev_addr_q;
    assign ev_wdata = ev_wdata_q;
    assign ev_pc    = ev_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_model_ctrl.sv
// ============================================================================
//  Module   : tb_dm_model_ctrl
//  Brief    : Directed bench for dm_model_ctrl: five instances (RD_LAT 0..4,
//             DEPTH 16, BASE 0x1000) driven by one shared request stream.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_model_ctrl;

    localparam int NL = 5;
    localparam int M  = 2;   // instance with RD_LAT = 2 carries the main checks

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_byteen = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rd_en = 1'b0;

    logic [31:0] rd_data_a  [NL];
    logic        rd_valid_a [NL];
    logic        busy_a     [NL];
    logic        err_a      [NL];
    logic        ev_valid_a [NL];
    logic [31:0] ev_addr_a  [NL];
    logic [31:0] ev_wdata_a [NL];
    logic [31:0] ev_pc_a    [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        dm_model_ctrl #(
            .DEPTH  (16),
            .BASE   (32'h0000_1000),
            .RD_LAT (g)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_addr   (req_addr),
            .req_byteen (req_byteen),
            .req_wdata  (req_wdata),
            .req_pc     (req_pc),
            .rd_en      (rd_en),
            .rd_data    (rd_data_a[g]),
            .rd_valid   (rd_valid_a[g]),
            .busy       (busy_a[g]),
            .err_oob    (err_a[g]),
            .ev_valid   (ev_valid_a[g]),
            .ev_addr    (ev_addr_a[g]),
            .ev_wdata   (ev_wdata_a[g]),
            .ev_pc      (ev_pc_a[g])
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        rd;
        logic        ev;
        logic [31:0] ev_addr;
        logic [31:0] ev_wdata;
        logic        err;
        logic        rdv;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] lat_data [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] pc, input logic rd);
        req_addr   = a;
        req_byteen = be;
        req_wdata  = wd;
        req_pc     = pc;
        rd_en      = rd;
    endtask

    task automatic idle();
        drive(32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic read_main(input logic [31:0] a, output logic v, output logic [31:0] d);
        @(negedge clk);
        drive(a, 4'h0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        v = rd_valid_a[M];
        d = rd_data_a[M];
    endtask

    // Counts busy cycles after release while hammering the DUT with requests
    // that must all be dropped.
    task automatic count_clear(input string tag);
        int   cnt;
        logic bad;
        cnt = 0;
        bad = 1'b0;
        #1;
        while (cnt < 100 && busy_a[M]) begin
            cnt++;
            drive(32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0BAD, 1'b1);
            #1;
            for (int l = 0; l < NL; l++) bad |= rd_valid_a[l] | err_a[l] | ev_valid_a[l];
            @(negedge clk);
            idle();
            #1;
        end
        for (int c = 0; c < 6; c++) begin
            for (int l = 0; l < NL; l++) bad |= rd_valid_a[l] | err_a[l] | ev_valid_a[l];
            @(negedge clk);
            #1;
        end
        chk({tag, "_busy_len"}, 32'(cnt), 32'd16);
        chk({tag, "_drop"}, 32'(bad), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        logic        v;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            read_main(32'h0000_1000 + 32'(4 * i), v, d);
            chk($sformatf("%s_rdv%0d", tag, i), 32'(v), 32'd1);
            chk($sformatf("%s_rd%0d", tag, i), d, 32'h0);
        end
    endtask

    initial begin
        //     addr           be     wdata          pc             rd    ev    ev_addr        ev_wdata       err   rdv   rdata
        vecs[0]  = '{32'h0000_1008, 4'hF, 32'h1122_3344, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_1008, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_1008, 4'h5, 32'hAABB_CCDD, 32'h0000_0104, 1'b0, 1'b1, 32'h0000_1008, 32'h11BB_33DD, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{32'h0000_1008, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h11BB_33DD};
        vecs[3]  = '{32'h0000_1040, 4'hF, 32'h1234_5678, 32'h0000_0200, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
        vecs[4]  = '{32'h0000_0FFC, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0};
        vecs[5]  = '{32'h0000_103F, 4'hF, 32'hCAFE_F00D, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_103C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{32'h0000_103C, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 32'h0000_010C, 1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{32'h0000_2000, 4'hF, 32'h5555_5555, 32'h0000_0110, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0};
        vecs[9]  = '{32'h0000_1004, 4'h8, 32'h5500_0000, 32'h0000_0114, 1'b1, 1'b1, 32'h0000_1004, 32'h55AD_BEEF, 1'b0, 1'b1, 32'h55AD_BEEF};
        vecs[10] = '{32'hFFFF_F000, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0};
        lat_data[0] = 32'h0101_0101;
        lat_data[1] = 32'h0202_0202;
        lat_data[2] = 32'h0303_0303;
        lat_data[3] = 32'h0404_0404;

        // Reset values and post-reset clear
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy_a[M]), 32'd1);
        chk("rst_rdv", 32'(rd_valid_a[M]), 32'd0);
        chk("rst_rdata", rd_data_a[M], 32'h0);
        chk("rst_err", 32'(err_a[M]), 32'd0);
        chk("rst_ev", 32'(ev_valid_a[M]), 32'd0);
        chk("rst_ev_addr", ev_addr_a[M], 32'h0);
        chk("rst_ev_wdata", ev_wdata_a[M], 32'h0);
        chk("rst_ev_pc", ev_pc_a[M], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        count_clear("clr");
        check_all_zero("clr");

        // Table-driven single transactions on the RD_LAT=2 instance
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].pc, vecs[i].rd);
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("v%0d_ev", i), 32'(ev_valid_a[M]), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_ev_addr", i), ev_addr_a[M], vecs[i].ev_addr);
                chk($sformatf("v%0d_ev_wdata", i), ev_wdata_a[M], vecs[i].ev_wdata);
                chk($sformatf("v%0d_ev_pc", i), ev_pc_a[M], vecs[i].pc);
            end
            chk($sformatf("v%0d_err", i), 32'(err_a[M]), 32'(vecs[i].err));
            chk($sformatf("v%0d_rdv_early", i), 32'(rd_valid_a[M]), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_rdv", i), 32'(rd_valid_a[M]), 32'(vecs[i].rdv));
            chk($sformatf("v%0d_rdata", i), rd_data_a[M], vecs[i].rdata);
            chk($sformatf("v%0d_err_once", i), 32'(err_a[M]), 32'd0);
            chk($sformatf("v%0d_ev_once", i), 32'(ev_valid_a[M]), 32'd0);
        end

        // Latency across RD_LAT 0..4: one read, then a 4-deep burst
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(32'h0000_1000 + 32'(4 * i), 4'hF, lat_data[i], 32'h0, 1'b0);
        end
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        drive(32'h0000_1008, 4'h0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                @(negedge clk);
                idle();
            end
            #1;
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("lat%0d_k%0d_v", l, k), 32'(rd_valid_a[l]), 32'(k == l));
                chk($sformatf("lat%0d_k%0d_d", l, k), rd_data_a[l], (k == l) ? lat_data[2] : 32'h0);
            end
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 4) drive(32'h0000_1000 + 32'(4 * k), 4'h0, 32'h0, 32'h0, 1'b1);
            else idle();
            #1;
            for (int l = 0; l < NL; l++) begin
                logic ev_exp;
                ev_exp = (k >= l) && (k < l + 4);
                chk($sformatf("burst%0d_k%0d_v", l, k), 32'(rd_valid_a[l]), 32'(ev_exp));
                chk($sformatf("burst%0d_k%0d_d", l, k), rd_data_a[l], ev_exp ? lat_data[k - l] : 32'h0);
            end
        end

        // Reset in the middle of clearing restarts the full sweep
        @(negedge clk);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_clear("midclr");
        check_all_zero("midclr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
